rr_arbiter_3x8: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 decoded resource among 8 requesters.
- Picks one requester, drives the 3-bit select index and the matching one-hot grant (decoder-equivalent), holds it until release, then rotates priority.
- Sits in front of the 3x8 decoder datapath: gnt_idx feeds the decoder select, gnt_valid feeds its enable.

---
 rtl/rr_arbiter_3x8.sv | 93 +++++++++
 tb/tb_rr_arbiter_3x8.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter_3x8.sv
// Round-robin arbiter: 8 requesters share one 3x8-decoded resource; grant held until release.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (adds MAX_HOLD parameter).
module rr_arbiter_3x8 #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             timeout;
  logic             rel;

  // First set request scanning from ptr upward; the 3-bit add wraps 7 -> 0.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign timeout = (hold_cnt == 8'(MAX_HOLD - 1));

  // Counts cycles spent in GRANT; zero in IDLE so every new grant starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    hold_cnt <= '0;
    else if (state == GRANT && !rel) hold_cnt <= hold_cnt + 8'd1;
    else                           hold_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  assign rel = done | ~req[gnt_idx] | ~en | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state     <= GRANT;
            gnt       <= N_REQ'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            ptr       <= win_idx + IDX_W'(1);
          end
        end
        GRANT: begin
          // Release always lands in IDLE, which guarantees the dead cycle.
          if (rel) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_3x8.sv
// Directed-vector bench for rr_arbiter_3x8; expected grants are hand-computed.
module tb_rr_arbiter_3x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter_3x8 #(.MAX_HOLD(4)) dut (
`else
  rr_arbiter_3x8 dut (
`endif
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic v, input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1;
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".idx"},   32'(gnt_idx),   v ? 32'(idx) : 32'd0);
    chk({tag, ".gnt"},   32'(gnt),       v ? 32'(one << idx) : 32'd0);
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;
    #3;
    chk_gnt("reset", 1'b0, 3'd0);
    step(2);
    rst_n = 1'b1;

    // Basic grant and done release
    en = 1'b1; req = 8'b0000_0001;
    step(1); chk_gnt("g0", 1'b1, 3'd0);
    done = 1'b1;
    step(1); chk_gnt("g0_rel", 1'b0, 3'd0);
    done = 1'b0; req = '0;

    // Alternating 2 / 7 with one dead cycle between grants (ptr=1 here)
    req = 8'b1000_0100;
    step(1); chk_gnt("alt_a2", 1'b1, 3'd2);
    done = 1'b1; step(1); chk_gnt("alt_dead1", 1'b0, 3'd0);
    done = 1'b0; step(1); chk_gnt("alt_b7", 1'b1, 3'd7);
    done = 1'b1; step(1); chk_gnt("alt_dead2", 1'b0, 3'd0);
    done = 1'b0; step(1); chk_gnt("alt_c2", 1'b1, 3'd2);
    done = 1'b1; step(1); chk_gnt("alt_dead3", 1'b0, 3'd0);
    done = 1'b0; step(1); chk_gnt("alt_d7", 1'b1, 3'd7);

    // Wrap: after 7, ptr=0 so requester 0 beats 7
    done = 1'b1; step(1); chk_gnt("wrap_rel", 1'b0, 3'd0);
    done = 1'b0; req = 8'b1000_0001;
    step(1); chk_gnt("wrap_g0", 1'b1, 3'd0);
    req = '0;
    step(1); chk_gnt("withdraw", 1'b0, 3'd0);

    // en=0 forces release and blocks grants (ptr=1)
    req = 8'b0000_1000;
    step(1); chk_gnt("en_g3", 1'b1, 3'd3);
    en = 1'b0;
    step(1); chk_gnt("en_rel", 1'b0, 3'd0);
    req = 8'hFF;
    step(2); chk_gnt("en_block", 1'b0, 3'd0);
    en = 1'b1;
    step(1); chk_gnt("en_g4", 1'b1, 3'd4);

    // Async reset between edges mid-grant
    #2 rst_n = 1'b0;
    #1 chk_gnt("async_rst", 1'b0, 3'd0);
    step(1);
    rst_n = 1'b1;
    step(1); chk_gnt("rst_g0", 1'b1, 3'd0);

    // done with pending requests: release first, then next winner from ptr=1
    done = 1'b1;
    step(1); chk_gnt("sim_rel", 1'b0, 3'd0);
    done = 1'b0;
    step(1); chk_gnt("sim_g1", 1'b1, 3'd1);
    // done in IDLE is ignored; requests still get granted next cycle
    req = '0;
    step(1); chk_gnt("idle_rel", 1'b0, 3'd0);
    done = 1'b1; req = 8'b0010_0000;
    step(1); chk_gnt("idle_done", 1'b1, 3'd5);
    done = 1'b0; req = '0;
    step(1); chk_gnt("idle_done_rel", 1'b0, 3'd0);

    // Hold behaviour with requester 5 held and done low (ptr=6)
    req = 8'b0010_0000;
    step(1); chk_gnt("hold_g5", 1'b1, 3'd5);
`ifdef ARB_TIMEOUT_EN
    step(1); chk_gnt("to_c1", 1'b1, 3'd5);
    step(1); chk_gnt("to_c2", 1'b1, 3'd5);
    step(1); chk_gnt("to_c3", 1'b1, 3'd5);
    step(1); chk_gnt("to_dead", 1'b0, 3'd0);
    step(1); chk_gnt("to_regnt", 1'b1, 3'd5);
`else
    begin
      int high = 0;
      for (int i = 0; i < 20; i++) begin
        step(1);
        if (gnt_valid === 1'b1 && gnt_idx === 3'd5) high++;
      end
      chk("hold_cycles", 32'(high), 32'd20);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
